// File: rtl/pipe_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_fwd_ctrl
//
// ID-stage forwarding and hazard controller for a five-stage pipeline.
// Shadows the destination register of the instructions currently in EX and
// MEM. From these it computes the operand-forwarding selects that the execute
// stage uses one cycle later. It also detects load-use hazards, which stall the
// pipeline for one cycle, and taken branches in EX, which flush it.
//
// Ports:
//   Clk, Rst            clock and asynchronous active-high reset
//   D_rs, D_rt          source registers of the ID instruction
//   D_use_rs, D_use_rt  ID instruction actually reads rs / rt
//   D_wn, D_wreg        ID destination register and its write enable
//   D_m2reg             ID instruction is a load
//   E_beq, E_bne, E_Z   branch type in EX and the ALU zero flag
//   E_FwdA, E_FwdB      registered EX operand selects
//                       (00 regfile, 01 W_Din, 10 M_ALUR)
//   Stall               combinational load-use stall
//   PC_en, D_en         PC and IF/ID enables, both equal to ~Stall
//   Flush               combinational taken-branch squash
//   StallCnt            saturating count of stall cycles
// -----------------------------------------------------------------------------
module pipe_fwd_ctrl #(
  parameter int CNTW = 16
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic [4:0]      D_rs,
  input  logic [4:0]      D_rt,
  input  logic            D_use_rs,
  input  logic            D_use_rt,
  input  logic [4:0]      D_wn,
  input  logic            D_wreg,
  input  logic            D_m2reg,
  input  logic            E_beq,
  input  logic            E_bne,
  input  logic            E_Z,
  output logic [1:0]      E_FwdA,
  output logic [1:0]      E_FwdB,
  output logic            Stall,
  output logic            PC_en,
  output logic            D_en,
  output logic            Flush,
  output logic [CNTW-1:0] StallCnt
);

  // Shadow copies of the destination fields of the EX and MEM instructions.
  logic [4:0] e_wn;
  logic       e_wreg;
  logic       e_m2reg;
  logic [4:0] m_wn;
  logic       m_wreg;

  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       load_use;
  logic       bubble;

  // The select is computed while the consumer is still in ID. The EX producer
  // will then be in MEM (select M_ALUR), and the MEM producer will be in WB
  // (select W_Din). The younger producer wins. Register $0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       use_src,
    input logic [4:0] ex_wn,
    input logic       ex_wreg,
    input logic [4:0] mem_wn,
    input logic       mem_wreg
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (use_src && (src != 5'd0)) begin
      if (ex_wreg && (ex_wn == src))        sel = 2'b10;
      else if (mem_wreg && (mem_wn == src)) sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    fwd_a = fwd_sel(D_rs, D_use_rs, e_wn, e_wreg, m_wn, m_wreg);
    fwd_b = fwd_sel(D_rt, D_use_rt, e_wn, e_wreg, m_wn, m_wreg);

    // Flush is held low during reset, so the branch inputs are ignored then.
    Flush = ~Rst & ((E_beq & E_Z) | (E_bne & ~E_Z));

    // A load in EX has no data to forward yet, so its consumer waits one cycle.
    load_use = e_wreg & e_m2reg & (e_wn != 5'd0) &
               ((D_use_rs & (D_rs == e_wn)) | (D_use_rt & (D_rt == e_wn)));

    // A taken branch discards the ID instruction, so its hazard does not matter.
    Stall  = load_use & ~Flush;
    PC_en  = ~Stall;
    D_en   = ~Stall;
    bubble = Stall | Flush;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      e_wn     <= 5'd0;
      e_wreg   <= 1'b0;
      e_m2reg  <= 1'b0;
      m_wn     <= 5'd0;
      m_wreg   <= 1'b0;
      E_FwdA   <= 2'b00;
      E_FwdB   <= 2'b00;
      StallCnt <= '0;
    end else begin
      m_wn   <= e_wn;
      m_wreg <= e_wreg;
      if (bubble) begin
        e_wn    <= 5'd0;
        e_wreg  <= 1'b0;
        e_m2reg <= 1'b0;
        E_FwdA  <= 2'b00;
        E_FwdB  <= 2'b00;
      end else begin
        e_wn    <= D_wn;
        e_wreg  <= D_wreg;
        e_m2reg <= D_m2reg;
        E_FwdA  <= fwd_a;
        E_FwdB  <= fwd_b;
      end
      if (Stall && (StallCnt != {CNTW{1'b1}})) begin
        StallCnt <= StallCnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_fwd_ctrl
//
// Bench for pipe_fwd_ctrl. The stall counter is narrowed to 3 bits here so
// that saturation is reached during the random phase.
// -----------------------------------------------------------------------------
module tb_pipe_fwd_ctrl;

  localparam int CW      = 3;
  localparam int CNT_MAX = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4:0]    d_rs, d_rt, d_wn;
  logic          d_use_rs, d_use_rt, d_wreg, d_m2reg;
  logic          e_beq, e_bne, e_z;
  logic [1:0]    e_fwd_a, e_fwd_b;
  logic          stall, pc_en, d_en, flush;
  logic [CW-1:0] stall_cnt;

  pipe_fwd_ctrl #(.CNTW(CW)) dut (
    .Clk(clk), .Rst(rst),
    .D_rs(d_rs), .D_rt(d_rt), .D_use_rs(d_use_rs), .D_use_rt(d_use_rt),
    .D_wn(d_wn), .D_wreg(d_wreg), .D_m2reg(d_m2reg),
    .E_beq(e_beq), .E_bne(e_bne), .E_Z(e_z),
    .E_FwdA(e_fwd_a), .E_FwdB(e_fwd_b),
    .Stall(stall), .PC_en(pc_en), .D_en(d_en), .Flush(flush),
    .StallCnt(stall_cnt)
  );

  // ---------------- stimulus records ----------------
  typedef struct {
    logic [4:0] rs, rt, wn;
    logic       use_rs, use_rt, wreg, m2reg;
    logic       beq, bne, z;
  } ins_t;

  typedef struct {
    ins_t     in;
    logic     st, fl;
    logic [1:0] fa, fb;
    int       cnt;
  } vec_t;

  // One in-flight instruction as the reference model sees it.
  typedef struct {
    logic [4:0] wn;
    logic       wreg;
    logic       m2reg;
  } pinst_t;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // pipe_q[0] is the instruction in EX, pipe_q[1] the one in MEM.
  pinst_t pipe_q[$];
  int     m_fa, m_fb, m_cnt;

  function automatic pinst_t empty_slot();
    pinst_t p;
    p.wn = 0; p.wreg = 0; p.m2reg = 0;
    return p;
  endfunction

  task automatic model_reset();
    pipe_q = {};
    pipe_q.push_back(empty_slot());
    pipe_q.push_back(empty_slot());
    m_fa = 0; m_fb = 0; m_cnt = 0;
  endtask

  // Find the youngest in-flight writer of src. Next cycle it is one stage
  // further on: EX -> MEM (select 2), MEM -> WB (select 1).
  function automatic int producer(input int src, input bit used);
    if (!used || src == 0) return 0;
    for (int k = 0; k < 2; k++)
      if (pipe_q[k].wreg && int'(pipe_q[k].wn) == src) return (k == 0) ? 2 : 1;
    return 0;
  endfunction

  function automatic bit m_flush(input ins_t in);
    return (in.beq && in.z) || (in.bne && !in.z);
  endfunction

  function automatic bit m_stall(input ins_t in);
    pinst_t ex;
    bit     hz;
    ex = pipe_q[0];
    hz = ex.wreg && ex.m2reg && ex.wn != 0 &&
         ((in.use_rs && in.rs == ex.wn) || (in.use_rt && in.rt == ex.wn));
    return hz && !m_flush(in);
  endfunction

  task automatic model_tick(input ins_t in);
    pinst_t nx;
    bit     st, fl;
    st = m_stall(in);
    fl = m_flush(in);
    if (st || fl) begin
      nx = empty_slot();
      m_fa = 0; m_fb = 0;
    end else begin
      nx.wn = in.wn; nx.wreg = in.wreg; nx.m2reg = in.m2reg;
      m_fa = producer(in.rs, in.use_rs);
      m_fb = producer(in.rt, in.use_rt);
    end
    if (st && m_cnt < CNT_MAX) m_cnt++;
    pipe_q.push_front(nx);
    void'(pipe_q.pop_back());
  endtask

  // ---------------- driver ----------------
  task automatic drive(input ins_t in);
    d_rs = in.rs; d_rt = in.rt; d_use_rs = in.use_rs; d_use_rt = in.use_rt;
    d_wn = in.wn; d_wreg = in.wreg; d_m2reg = in.m2reg;
    e_beq = in.beq; e_bne = in.bne; e_z = in.z;
  endtask

  function automatic ins_t mk(input int rs, input int rt, input bit urs, input bit urt,
                              input int wn, input bit wr, input bit ld,
                              input bit beq, input bit bne, input bit z);
    ins_t i;
    i.rs = 5'(rs); i.rt = 5'(rt); i.use_rs = urs; i.use_rt = urt;
    i.wn = 5'(wn); i.wreg = wr; i.m2reg = ld; i.beq = beq; i.bne = bne; i.z = z;
    return i;
  endfunction

  function automatic vec_t v(input ins_t in, input bit st, input bit fl,
                             input int fa, input int fb, input int cnt);
    vec_t r;
    r.in = in; r.st = st; r.fl = fl; r.fa = 2'(fa); r.fb = 2'(fb); r.cnt = cnt;
    return r;
  endfunction

  vec_t tab[21];

  initial begin
    ins_t in;
    ins_t hold;
    bit   held;

    //          rs  rt urs urt wn wr ld beq bne z      st fl fa fb cnt
    tab[0]  = v(mk( 4, 5, 1, 1,  1, 1, 0, 0, 0, 0),   0, 0, 0, 0, 0); // add $1
    tab[1]  = v(mk( 1, 6, 1, 1,  7, 1, 0, 0, 0, 0),   0, 0, 2, 0, 0); // uses $1, dist 1
    tab[2]  = v(mk( 0, 0, 0, 0,  0, 0, 0, 0, 0, 0),   0, 0, 0, 0, 0); // nop
    tab[3]  = v(mk( 8, 9, 1, 1,  3, 1, 0, 0, 0, 0),   0, 0, 0, 0, 0); // add $3
    tab[4]  = v(mk( 0, 0, 0, 0,  0, 0, 0, 0, 0, 0),   0, 0, 0, 0, 0); // nop
    tab[5]  = v(mk(10, 3, 1, 1, 11, 1, 0, 0, 0, 0),   0, 0, 0, 1, 0); // rt=$3, dist 2
    tab[6]  = v(mk(13,14, 1, 1, 12, 1, 0, 0, 0, 0),   0, 0, 0, 0, 0); // add $12
    tab[7]  = v(mk( 0, 0, 0, 0, 12, 1, 0, 0, 0, 0),   0, 0, 0, 0, 0); // add $12 again
    tab[8]  = v(mk(11,12, 1, 1,  0, 0, 0, 0, 0, 0),   0, 0, 0, 2, 0); // EX beats MEM
    tab[9]  = v(mk(15, 0, 1, 0,  2, 1, 1, 0, 0, 0),   0, 0, 0, 0, 0); // lw $2
    tab[10] = v(mk( 2,16, 1, 1, 17, 1, 0, 0, 0, 0),   1, 0, 0, 0, 1); // load-use stall
    tab[11] = v(mk( 2,16, 1, 1, 17, 1, 0, 0, 0, 0),   0, 0, 1, 0, 1); // replay -> W_Din
    tab[12] = v(mk(18,19, 1, 1,  0, 1, 1, 0, 0, 0),   0, 0, 0, 0, 1); // lw $0
    tab[13] = v(mk( 0,17, 1, 0, 21, 1, 1, 0, 0, 0),   0, 0, 0, 0, 1); // $0 use, rt unused
    tab[14] = v(mk(21, 0, 1, 0, 22, 1, 0, 1, 0, 1),   0, 1, 0, 0, 1); // beq taken over hazard
    tab[15] = v(mk(21, 0, 1, 0,  0, 0, 0, 0, 1, 1),   0, 0, 1, 0, 1); // bne Z=1 not taken
    tab[16] = v(mk( 0, 0, 0, 0,  5, 1, 1, 0, 0, 0),   0, 0, 0, 0, 1); // lw $5
    tab[17] = v(mk( 0, 5, 0, 1,  6, 1, 1, 0, 0, 0),   1, 0, 0, 0, 2); // lw $6 uses $5
    tab[18] = v(mk( 0, 5, 0, 1,  6, 1, 1, 0, 0, 0),   0, 0, 0, 1, 2);
    tab[19] = v(mk( 6, 0, 1, 0,  7, 1, 0, 0, 0, 0),   1, 0, 0, 0, 3); // uses $6
    tab[20] = v(mk( 6, 0, 1, 0,  7, 1, 0, 0, 0, 0),   0, 0, 1, 0, 3);

    // ---------------- reset ----------------
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fwd_a", e_fwd_a, 0);
    chk("rst_fwd_b", e_fwd_b, 0);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_pc_en", pc_en, 1);
    rst = 1'b0;

    // ---------------- directed table ----------------
    foreach (tab[i]) begin
      drive(tab[i].in);
      #1;
      chk($sformatf("tab%0d_stall", i), stall, tab[i].st);
      chk($sformatf("tab%0d_flush", i), flush, tab[i].fl);
      chk($sformatf("tab%0d_pc_en", i), pc_en, !tab[i].st);
      chk($sformatf("tab%0d_d_en", i), d_en, !tab[i].st);
      @(posedge clk);
      model_tick(tab[i].in);
      #1;
      chk($sformatf("tab%0d_fwd_a", i), e_fwd_a, tab[i].fa);
      chk($sformatf("tab%0d_fwd_b", i), e_fwd_b, tab[i].fb);
      chk($sformatf("tab%0d_cnt", i), stall_cnt, tab[i].cnt);
    end

    // ---------------- random traffic against the model ----------------
    held = 0;
    hold = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      if (held) begin
        in = hold;
      end else begin
        in = mk($urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 1));
      end
      drive(in);
      #1;
      chk("rnd_stall", stall, m_stall(in));
      chk("rnd_flush", flush, m_flush(in));
      chk("rnd_pc_en", pc_en, !m_stall(in));
      // A stalled instruction stays in ID with its operand fields unchanged.
      held = m_stall(in);
      hold = in;
      hold.beq = 0; hold.bne = 0;
      @(posedge clk);
      model_tick(in);
      #1;
      chk("rnd_fwd_a", e_fwd_a, m_fa);
      chk("rnd_fwd_b", e_fwd_b, m_fb);
      chk("rnd_cnt", stall_cnt, m_cnt);
    end
    chk("rnd_cnt_saturated", stall_cnt, CNT_MAX);

    // ---------------- reset in the middle of traffic ----------------
    drive(mk(0, 0, 0, 0, 9, 1, 1, 0, 0, 0));          // lw $9
    @(posedge clk);
    #1;
    drive(mk(9, 9, 1, 1, 10, 1, 0, 1, 0, 1));         // consumer of $9 plus beq taken
    #1;
    chk("pre_rst_flush", flush, 1);
    drive(mk(9, 9, 1, 1, 10, 1, 0, 0, 0, 0));
    #1;
    chk("pre_rst_stall", stall, 1);
    e_beq = 1'b1; e_z = 1'b1;                          // branch inputs active across reset
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_flush", flush, 0);
    chk("mid_rst_pc_en", pc_en, 1);
    chk("mid_rst_d_en", d_en, 1);
    chk("mid_rst_cnt", stall_cnt, 0);
    chk("mid_rst_fwd_a", e_fwd_a, 0);
    chk("mid_rst_fwd_b", e_fwd_b, 0);
    @(negedge clk);
    rst = 1'b0;
    e_beq = 1'b0; e_z = 1'b0;
    model_reset();
    #1;
    chk("post_rst_stall", stall, 0);
    @(posedge clk);
    #1;
    chk("post_rst_fwd_a", e_fwd_a, 0);
    chk("post_rst_fwd_b", e_fwd_b, 0);
    chk("post_rst_cnt", stall_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
